// File: rtl/posit_decode_pipe_if.sv
// Handshake and decoded-field bundle for posit_decode_pipe.
// PDEC_SCALE_EN adds the signed out_scale field.
interface posit_decode_pipe_if #(
  parameter int N  = 16,
  parameter int ES = 1
);
  localparam int ES_W = (ES > 0) ? ES : 1;
  localparam int K_W  = $clog2(N) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0]          posit_in;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sign;
  logic signed [K_W-1:0] out_k;
  logic [ES_W-1:0]       out_exp;
  logic [N-2:0]          out_frac;
  logic                  out_is_zero;
  logic                  out_is_nar;
`ifdef PDEC_SCALE_EN
  logic signed [K_W+ES-1:0] out_scale;

  modport master (
    output in_valid, posit_in, out_ready,
    input  in_ready, out_valid, out_sign, out_k, out_exp, out_frac,
           out_is_zero, out_is_nar, out_scale
  );
  modport slave (
    input  in_valid, posit_in, out_ready,
    output in_ready, out_valid, out_sign, out_k, out_exp, out_frac,
           out_is_zero, out_is_nar, out_scale
  );
`else
  modport master (
    output in_valid, posit_in, out_ready,
    input  in_ready, out_valid, out_sign, out_k, out_exp, out_frac,
           out_is_zero, out_is_nar
  );
  modport slave (
    input  in_valid, posit_in, out_ready,
    output in_ready, out_valid, out_sign, out_k, out_exp, out_frac,
           out_is_zero, out_is_nar
  );
`endif
endinterface

// File: rtl/posit_decode_pipe.sv
// Two-stage posit field decoder (sign/regime/exponent/fraction, zero/NaR flags).
// Optional PDEC_SCALE_EN adds a registered signed scale = (k << ES) + exp.

// Count of leading bits of 'bits' equal to 'val'.
module cls #(
  parameter int W = 15
) (
  input  logic                     val,
  input  logic [W-1:0]             bits,
  output logic [$clog2(W+1)-1:0]   count
);
  logic run;

  always_comb begin
    count = '0;
    run   = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      if (run && (bits[W-1-i] == val)) count = count + 1'b1;
      else                             run   = 1'b0;
    end
  end
endmodule

module posit_decode_pipe #(
  parameter int N  = 16,
  parameter int ES = 1
) (
  input logic                 clk,
  input logic                 rst,
  posit_decode_pipe_if.slave  bus
);
  localparam int ES_W = (ES > 0) ? ES : 1;
  localparam int K_W  = $clog2(N) + 1;
  localparam int MW   = $clog2(N);
  localparam int SC_W = K_W + ES;

  logic adv;

  // Stage 1 combinational decode
  logic          sign1;
  logic [N-2:0]  body1;
  logic          zero1;
  logic          nar1;
  logic [MW-1:0] m1;

  // Stage 1 registers
  logic          s1_valid;
  logic          s1_sign;
  logic          s1_zero;
  logic          s1_nar;
  logic [MW-1:0] s1_m;
  logic [N-2:0]  s1_body;

  // Stage 2 combinational decode
  logic                  r2;
  logic signed [K_W-1:0] m_s2;
  logic signed [K_W-1:0] k2;
  logic [N-2:0]          rest2;
  logic [N-2:0]          frac2;
  logic [ES_W-1:0]       exp2;
  logic                  special2;

  // Output registers
  logic                  ov_q;
  logic                  os_q;
  logic signed [K_W-1:0] ok_q;
  logic [ES_W-1:0]       oe_q;
  logic [N-2:0]          of_q;
  logic                  oz_q;
  logic                  on_q;

  assign adv          = ~ov_q | bus.out_ready;
  assign bus.in_ready = adv;

  assign sign1 = bus.posit_in[N-1];
  assign body1 = sign1 ? (~bus.posit_in[N-2:0] + 1'b1) : bus.posit_in[N-2:0];
  assign zero1 = (bus.posit_in == '0);
  assign nar1  = (bus.posit_in == {1'b1, {(N-1){1'b0}}});

  cls #(.W(N-1)) u_cls (
    .val   (body1[N-2]),
    .bits  (body1),
    .count (m1)
  );

  // A full-width regime (m = N-1) has no terminating bit; m+1 would also
  // overflow MW when N is a power of two, so it takes the explicit zero path.
  always_comb begin
    r2       = s1_body[N-2];
    m_s2     = $signed({1'b0, s1_m});
    k2       = r2 ? (m_s2 - K_W'(1)) : -m_s2;
    rest2    = (s1_m == MW'(N-1)) ? '0 : (s1_body << (s1_m + 1'b1));
    frac2    = rest2 << ES;
    special2 = s1_zero | s1_nar;
  end

  if (ES > 0) begin : g_exp
    assign exp2 = rest2[N-2 -: ES_W];
  end else begin : g_noexp
    assign exp2 = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_m     <= '0;
      s1_body  <= '0;
      ov_q     <= 1'b0;
      os_q     <= 1'b0;
      ok_q     <= '0;
      oe_q     <= '0;
      of_q     <= '0;
      oz_q     <= 1'b0;
      on_q     <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_sign  <= sign1;
      s1_zero  <= zero1;
      s1_nar   <= nar1;
      s1_m     <= m1;
      s1_body  <= body1;
      ov_q     <= s1_valid;
      os_q     <= special2 ? 1'b0 : s1_sign;
      ok_q     <= special2 ? '0 : k2;
      oe_q     <= special2 ? '0 : exp2;
      of_q     <= special2 ? '0 : frac2;
      oz_q     <= s1_zero;
      on_q     <= s1_nar;
    end
  end

  assign bus.out_valid   = ov_q;
  assign bus.out_sign    = os_q;
  assign bus.out_k       = ok_q;
  assign bus.out_exp     = oe_q;
  assign bus.out_frac    = of_q;
  assign bus.out_is_zero = oz_q;
  assign bus.out_is_nar  = on_q;

`ifdef PDEC_SCALE_EN
  logic signed [SC_W-1:0] scale2;
  logic signed [SC_W-1:0] osc_q;

  assign scale2 = (SC_W'(k2) <<< ES) + SC_W'(exp2);

  always_ff @(posedge clk) begin
    if (rst)      osc_q <= '0;
    else if (adv) osc_q <= special2 ? '0 : scale2;
  end

  assign bus.out_scale = osc_q;
`endif
endmodule

// File: tb/tb_posit_decode_pipe.sv
// Bench for posit_decode_pipe: three parameterisations share one stimulus stream
// and are checked every cycle against a bit-walking posit decode model.
module tb_posit_decode_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] pin = '0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  posit_decode_pipe_if #(.N(8),  .ES(0)) if_a ();
  posit_decode_pipe_if #(.N(8),  .ES(1)) if_b ();
  posit_decode_pipe_if #(.N(16), .ES(2)) if_c ();

  assign if_a.in_valid = in_valid; assign if_a.posit_in = pin[7:0]; assign if_a.out_ready = out_ready;
  assign if_b.in_valid = in_valid; assign if_b.posit_in = pin[7:0]; assign if_b.out_ready = out_ready;
  assign if_c.in_valid = in_valid; assign if_c.posit_in = pin;      assign if_c.out_ready = out_ready;

  posit_decode_pipe #(.N(8),  .ES(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  posit_decode_pipe #(.N(8),  .ES(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  posit_decode_pipe #(.N(16), .ES(2)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  typedef struct {
    bit sign; int k; int e; int frac; bit zero; bit nar; int scale;
  } dec_t;

  typedef struct { dec_t d; int acc; int st; } ent_t;

  ent_t q [3][$];
  int   stall [3] = '{0, 0, 0};

  function automatic int bit_at(int unsigned u, int pos);
    return (pos >= 0) ? int'((u >> pos) & 1) : 0;
  endfunction

  // Walk the posit bit by bit: sign, regime run, terminator, exponent, fraction.
  function automatic dec_t model(int n, int es, int unsigned p);
    dec_t d;
    int unsigned mask = (32'd1 << n) - 1;
    int unsigned u;
    int pos, m, r;
    d = '{default: 0};
    p = p & mask;
    if (p == 0) begin d.zero = 1; return d; end
    if (p == (32'd1 << (n - 1))) begin d.nar = 1; return d; end
    d.sign = bit'((p >> (n - 1)) & 1);
    u = d.sign ? ((~p + 1) & mask) : p;
    pos = n - 2;
    r = bit_at(u, pos);
    m = 0;
    while (pos >= 0 && bit_at(u, pos) == r) begin m++; pos--; end
    pos--;
    for (int i = 0; i < es; i++) begin d.e = d.e * 2 + bit_at(u, pos); pos--; end
    for (int i = 0; i < n - 1; i++) begin d.frac = d.frac * 2 + bit_at(u, pos); pos--; end
    d.k = (r != 0) ? m - 1 : -m;
    d.scale = d.k * (1 << es) + d.e;
    return d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pin_model(input string nm, input dec_t d, input int sg, input int k,
                           input int e, input int fr, input int z, input int na, input int sc);
    chk({nm, ".sign"}, int'(d.sign), sg);
    chk({nm, ".k"}, d.k, k);
    chk({nm, ".exp"}, d.e, e);
    chk({nm, ".frac"}, d.frac, fr);
    chk({nm, ".zero"}, int'(d.zero), z);
    chk({nm, ".nar"}, int'(d.nar), na);
    chk({nm, ".scale"}, d.scale, sc);
  endtask

  task automatic lane_step(input int ln, input int n, input int es, input logic ir,
                           input logic ov, input dec_t act);
    string nm;
    ent_t  f;
    nm = $sformatf("lane%0d", ln);
    chk({nm, ".in_ready"}, int'(ir), int'(!ov || out_ready));
    if (ov) begin
      if (q[ln].size() == 0) begin
        chk({nm, ".stale_output"}, 1, 0);
      end else begin
        f = q[ln][0];
        chk({nm, ".sign"}, int'(act.sign), int'(f.d.sign));
        chk({nm, ".k"}, act.k, f.d.k);
        chk({nm, ".exp"}, act.e, f.d.e);
        chk({nm, ".frac"}, act.frac, f.d.frac);
        chk({nm, ".is_zero"}, int'(act.zero), int'(f.d.zero));
        chk({nm, ".is_nar"}, int'(act.nar), int'(f.d.nar));
`ifdef PDEC_SCALE_EN
        chk({nm, ".scale"}, act.scale, f.d.scale);
`endif
        chk({nm, ".latency"}, cyc - f.acc - (stall[ln] - f.st), 2);
        if (out_ready) void'(q[ln].pop_front());
      end
    end
    if (rst) begin
      q[ln].delete();
    end else if (in_valid && ir) begin
      f.d = model(n, es, int'(pin));
      f.acc = cyc;
      f.st = stall[ln];
      q[ln].push_back(f);
    end
    if (ov && !out_ready) stall[ln]++;
  endtask

  always @(negedge clk) begin
    dec_t a, b, c;
    a = '{if_a.out_sign, int'(if_a.out_k), int'(if_a.out_exp), int'(if_a.out_frac),
          if_a.out_is_zero, if_a.out_is_nar, 0};
    b = '{if_b.out_sign, int'(if_b.out_k), int'(if_b.out_exp), int'(if_b.out_frac),
          if_b.out_is_zero, if_b.out_is_nar, 0};
    c = '{if_c.out_sign, int'(if_c.out_k), int'(if_c.out_exp), int'(if_c.out_frac),
          if_c.out_is_zero, if_c.out_is_nar, 0};
`ifdef PDEC_SCALE_EN
    a.scale = int'(if_a.out_scale);
    b.scale = int'(if_b.out_scale);
    c.scale = int'(if_c.out_scale);
`endif
    lane_step(0, 8, 0, if_a.in_ready, if_a.out_valid, a);
    lane_step(1, 8, 1, if_b.in_ready, if_b.out_valid, b);
    lane_step(2, 16, 2, if_c.in_ready, if_c.out_valid, c);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    in_valid = 1'b1;
    pin = v;
    step();
  endtask

  logic [15:0] specials [8] = '{16'h0000, 16'h0080, 16'h8000, 16'h007F,
                                16'h7FFF, 16'h0040, 16'h00C0, 16'hFFFF};

  initial begin
    // Hand-derived decodes pin the model itself.
    pin_model("m40",   model(8, 0, 'h40), 0,  0, 0, 'h00, 0, 0,  0);
    pin_model("m60",   model(8, 0, 'h60), 0,  1, 0, 'h00, 0, 0,  1);
    pin_model("m20",   model(8, 0, 'h20), 0, -1, 0, 'h00, 0, 0, -1);
    pin_model("m50",   model(8, 0, 'h50), 0,  0, 0, 'h40, 0, 0,  0);
    pin_model("mC0",   model(8, 0, 'hC0), 1,  0, 0, 'h00, 0, 0,  0);
    pin_model("m7F",   model(8, 0, 'h7F), 0,  6, 0, 'h00, 0, 0,  6);
    pin_model("m00",   model(8, 0, 'h00), 0,  0, 0, 'h00, 1, 0,  0);
    pin_model("m80",   model(8, 0, 'h80), 0,  0, 0, 'h00, 0, 1,  0);
    pin_model("m50e1", model(8, 1, 'h50), 0,  0, 1, 'h00, 0, 0,  1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; pin = '0;
    step(); step();
    rst = 1'b0;
    chk("reset.out_valid", int'(if_a.out_valid), 0);
    chk("reset.in_ready", int'(if_a.in_ready), 1);
    chk("reset.out_k", int'(if_a.out_k), 0);
    chk("reset.out_frac", int'(if_a.out_frac), 0);

    // Streaming directed values and boundary cases
    send(16'h0040); send(16'h0060); send(16'h0020); send(16'h0050);
    send(16'h00C0); send(16'h007F); send(16'h0000); send(16'h0080);
    in_valid = 1'b0;
    repeat (4) step();

    // Backpressure: out_ready low with 0x40 at the output, 0x60 behind it
    send(16'h0040); send(16'h0060);
    out_ready = 1'b0; in_valid = 1'b1; pin = 16'h0033;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.out_valid", int'(if_a.out_valid), 1);
      chk("bp.in_ready", int'(if_a.in_ready), 0);
      chk("bp.out_k", int'(if_a.out_k), 0);
      chk("bp.out_frac", int'(if_a.out_frac), 0);
      chk("bp.out_exp_b", int'(if_b.out_exp), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("bp.drained", q[0].size(), 0);

    // Reset with two items in flight
    send(16'h0020); send(16'h0050);
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst.out_valid", int'(if_a.out_valid), 0);
    chk("midrst.in_ready", int'(if_a.in_ready), 1);
    chk("midrst.out_k", int'(if_a.out_k), 0);
    chk("midrst.out_frac", int'(if_a.out_frac), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst.no_stale", int'(if_a.out_valid), 0);
    end

    // Randomised traffic with backpressure and occasional reset
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) pin = specials[$urandom_range(0, 7)];
      else                           pin = 16'($urandom);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && (q[0].size() + q[1].size() + q[2].size()) > 0; i++) step();
    step();
    chk("final.drain", q[0].size() + q[1].size() + q[2].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
